fft_seq: RTL

FFT_SEQ -- requirements
Module: fft_seq

---
 rtl/fft_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fft_seq.sv
// fft_seq: frame sequencer around an external FFT address controller.
// Walks each frame through IDLE -> LOAD -> COMPUTE -> READOUT, generating the
// natural-order RAM index (add_rd), the sample write enable, a one-cycle
// compute start pulse and a ready/valid readout handshake.
// Optional macro FFT_SEQ_CONT_EN: when defined, finishing READOUT goes
// straight back to LOAD (continuous framing) instead of IDLE.
module fft_seq #(
    parameter int N       = 9,  // log2 of FFT points
    parameter int FRAME_W = 8   // completed-frame counter width
) (
    input  logic               clk,
    input  logic               reset,        // asynchronous, active-low
    input  logic               frame_go,
    input  logic               abort,
    input  logic               sample_valid,
    output logic               sample_ready,
    output logic               fft_load,
    output logic               fft_start,
    input  logic               fft_done,
    output logic [N-1:0]       add_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               overrun,
    output logic [FRAME_W-1:0] frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_READOUT = 2'd3
    } state_t;

    localparam logic [N-1:0]       LAST_IDX  = {N{1'b1}};
    localparam logic [N-1:0]       IDX_ONE   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    // State after the last readout word: continuous mode skips IDLE.
`ifdef FFT_SEQ_CONT_EN
    localparam state_t S_AFTER_FRAME = S_LOAD;
`else
    localparam state_t S_AFTER_FRAME = S_IDLE;
`endif

    state_t             state_q, state_d;
    logic [N-1:0]       add_rd_q, add_rd_d;
    logic               out_valid_q, out_valid_d;
    logic               fft_start_q, fft_start_d;
    logic               overrun_q, overrun_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               busy_q, busy_d;

    // Next-state and datapath decisions; abort overrides every other event.
    always_comb begin
        state_d     = state_q;
        add_rd_d    = add_rd_q;
        out_valid_d = out_valid_q;
        fft_start_d = 1'b0;
        overrun_d   = overrun_q;
        frame_cnt_d = frame_cnt_q;

        if (abort) begin
            // Discard whatever is in flight; counters and sticky flag hold.
            state_d     = S_IDLE;
            add_rd_d    = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Stray samples in IDLE are ignored without flagging.
                    if (frame_go) begin
                        state_d   = S_LOAD;
                        add_rd_d  = '0;
                        overrun_d = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (sample_valid) begin
                        if (add_rd_q == LAST_IDX) begin
                            add_rd_d    = '0;
                            state_d     = S_COMPUTE;
                            fft_start_d = 1'b1;
                        end else begin
                            add_rd_d = add_rd_q + IDX_ONE;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (sample_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (fft_done) begin
                        state_d     = S_READOUT;
                        add_rd_d    = '0;
                        out_valid_d = 1'b0;
                    end
                end
                S_READOUT: begin
                    if (sample_valid) begin
                        overrun_d = 1'b1;
                    end
                    if (out_valid_q && out_ready) begin
                        // Word taken: advance and re-prime for the RAM latency.
                        out_valid_d = 1'b0;
                        if (add_rd_q == LAST_IDX) begin
                            add_rd_d    = '0;
                            frame_cnt_d = frame_cnt_q + FRAME_ONE;
                            state_d     = S_AFTER_FRAME;
                        end else begin
                            add_rd_d = add_rd_q + IDX_ONE;
                        end
                    end else begin
                        // RAM data at add_rd is valid one cycle after the address.
                        out_valid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // Sequencer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            add_rd_q    <= '0;
            out_valid_q <= 1'b0;
            fft_start_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            add_rd_q    <= add_rd_d;
            out_valid_q <= out_valid_d;
            fft_start_q <= fft_start_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    // Load handshake is purely a function of the current state.
    always_comb begin
        sample_ready = (state_q == S_LOAD);
        fft_load     = (state_q == S_LOAD) && sample_valid;
    end

    assign add_rd    = add_rd_q;
    assign out_valid = out_valid_q;
    assign fft_start = fft_start_q;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;
    assign busy      = busy_q;

endmodule
